// File: rtl/xbar_banki_rr.sv
// Multi-CPU to multi-bank memory crossbar.
// Each CPU word address splits into a bank number and an in-bank address. Every bank runs its
// own round-robin arbiter over the CPUs that target it. Responses (read data or write ack)
// return to the winning CPU exactly one cycle after the grant. Addresses that decode to a
// non-existent bank are accepted immediately and answered with an error response.
module xbar_banki_rr #(
  parameter int unsigned NUM_CPU            = 2,
  parameter int unsigned NUM_BANKS          = 3,
  parameter int unsigned SIZE_BANKI         = 32,
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned SHIRINA_BANKI      = $clog2(SIZE_BANKI),
  parameter int unsigned SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_CPU-1:0]                             cpu_req,
  input  logic [NUM_CPU-1:0]                             cpu_we,
  input  logic [NUM_CPU-1:0][SHIRINA_VSEH_BANOK-1:0]     cpu_addr,
  input  logic [NUM_CPU-1:0][DATA_W-1:0]                 cpu_wdata,
  output logic [NUM_CPU-1:0]                             cpu_gnt,
  output logic [NUM_CPU-1:0]                             cpu_rvalid,
  output logic [NUM_CPU-1:0][DATA_W-1:0]                 cpu_rdata,
  output logic [NUM_CPU-1:0]                             cpu_err,
  output logic [NUM_BANKS-1:0]                           bank_req,
  output logic [NUM_BANKS-1:0]                           bank_we,
  output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]        bank_addr,
  output logic [NUM_BANKS-1:0][DATA_W-1:0]               bank_wdata,
  input  logic [NUM_BANKS-1:0][DATA_W-1:0]               bank_rdata
);

  // CPU index width; kept at least 1 bit so a single-CPU build still has a legal vector.
  localparam int unsigned CW = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1;

  // Decoded address fields
  logic [31:0]        bank_num [NUM_CPU];
  logic [NUM_CPU-1:0] in_range;

  // Arbitration results per bank
  logic [NUM_BANKS-1:0]         bank_gnt;
  logic [NUM_BANKS-1:0][CW-1:0] winner;

  // State: round-robin pointers (last winner), per-bank response tracking, per-CPU error flag
  logic [NUM_BANKS-1:0][CW-1:0] ptr_q, ptr_d;
  logic [NUM_BANKS-1:0]         rsp_valid_q, rsp_valid_d;
  logic [NUM_BANKS-1:0][CW-1:0] rsp_owner_q, rsp_owner_d;
  logic [NUM_BANKS-1:0]         rsp_we_q, rsp_we_d;
  logic [NUM_CPU-1:0]           err_pend_q, err_pend_d;

  // Split each CPU address into bank number and range flag.
  // The shift works for any NUM_BANKS, including a single bank with an empty bank field.
  always_comb begin
    for (int c = 0; c < NUM_CPU; c++) begin
      bank_num[c] = 32'(cpu_addr[c]) >> SHIRINA_BANKI;
      in_range[c] = (bank_num[c] < NUM_BANKS);
    end
  end

  // Per-bank round-robin: first requester at or after ptr+1, wrapping modulo NUM_CPU.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    bank_gnt = '0;
    winner   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 1; k <= NUM_CPU; k++) begin
        idx = (32'(ptr_q[b]) + 32'(k)) % NUM_CPU;
        if (!bank_gnt[b] && cpu_req[idx] && in_range[idx] && bank_num[idx] == 32'(b)) begin
          bank_gnt[b] = 1'b1;
          winner[b]   = CW'(idx);
        end
      end
    end
  end

  // CPU grants: bank winners plus immediate acceptance of out-of-range requests.
  always_comb begin
    cpu_gnt = '0;
    if (rst_n) begin
      for (int c = 0; c < NUM_CPU; c++) begin
        if (cpu_req[c] && !in_range[c]) cpu_gnt[c] = 1'b1;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_gnt[b]) cpu_gnt[winner[b]] = 1'b1;
      end
    end
  end

  // Bank-side mux: drive the winner's access, all zeros on idle banks.
  always_comb begin
    bank_req   = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    if (rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_gnt[b]) begin
          bank_req[b]   = 1'b1;
          bank_we[b]    = cpu_we[winner[b]];
          bank_addr[b]  = cpu_addr[winner[b]][SHIRINA_BANKI-1:0];
          bank_wdata[b] = cpu_wdata[winner[b]];
        end
      end
    end
  end

  // Next state: pointer moves only on a grant; response slot records who owns next cycle's data.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = bank_gnt;
    rsp_owner_d = rsp_owner_q;
    rsp_we_d    = rsp_we_q;
    err_pend_d  = cpu_req & ~in_range;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_gnt[b]) begin
        ptr_d[b]       = winner[b];
        rsp_owner_d[b] = winner[b];
        rsp_we_d[b]    = cpu_we[winner[b]];
      end
    end
  end

  // State registers; reset discards any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b] <= CW'(NUM_CPU - 1);
      end
      rsp_valid_q <= '0;
      rsp_owner_q <= '0;
      rsp_we_q    <= '0;
      err_pend_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_we_q    <= rsp_we_d;
      err_pend_q  <= err_pend_d;
    end
  end

  // Response routing: one grant per CPU per cycle means at most one source per CPU here.
  always_comb begin
    cpu_rvalid = err_pend_q;
    cpu_err    = err_pend_q;
    cpu_rdata  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rsp_valid_q[b]) begin
        cpu_rvalid[rsp_owner_q[b]] = 1'b1;
        if (!rsp_we_q[b]) cpu_rdata[rsp_owner_q[b]] = bank_rdata[b];
      end
    end
  end

endmodule

// File: tb/tb_xbar_banki_rr.sv
// Directed bench for xbar_banki_rr with default parameters (2 CPUs, 3 banks of 32 words).
// Banks are modelled as simple SRAMs preloaded with 32'hA000_0000 | bank<<8 | word.
module tb_xbar_banki_rr;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            cpu_req;
  logic [1:0]            cpu_we;
  logic [1:0][6:0]       cpu_addr;
  logic [1:0][31:0]      cpu_wdata;
  logic [1:0]            cpu_gnt;
  logic [1:0]            cpu_rvalid;
  logic [1:0][31:0]      cpu_rdata;
  logic [1:0]            cpu_err;
  logic [2:0]            bank_req;
  logic [2:0]            bank_we;
  logic [2:0][4:0]       bank_addr;
  logic [2:0][31:0]      bank_wdata;
  logic [2:0][31:0]      bank_rdata;

  int check_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] mem [3][32];

  xbar_banki_rr dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .bank_req   (bank_req),
    .bank_we    (bank_we),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_rdata (bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, preloaded pattern restored on reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_rdata <= '0;
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < 32; a++)
          mem[b][a] <= 32'hA000_0000 | (32'(b) << 8) | 32'(a);
    end else begin
      for (int b = 0; b < 3; b++) begin
        if (bank_req[b]) begin
          if (bank_we[b]) mem[b][bank_addr[b]] <= bank_wdata[b];
          else            bank_rdata[b] <= mem[b][bank_addr[b]];
        end
      end
    end
  end

  task automatic idle();
    cpu_req   = '0;
    cpu_we    = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
  endtask

  // Step to the next clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    cpu_req     = 2'b01;
    cpu_addr[0] = 7'd5;
    tick();
    tick();
    check_cnt++;
    if (cpu_gnt !== 2'b00) $display("FAIL reset_gnt got %b want 00", cpu_gnt);
    else pass_cnt++;
    check_cnt++;
    if (bank_req !== 3'b000) $display("FAIL reset_bank_req got %b want 000", bank_req);
    else pass_cnt++;
    check_cnt++;
    if (cpu_rvalid !== 2'b00 || cpu_err !== 2'b00 || cpu_rdata !== '0)
      $display("FAIL reset_rsp got rvalid=%b err=%b rdata=%h want zeros",
               cpu_rvalid, cpu_err, cpu_rdata);
    else pass_cnt++;
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    cpu_req     = 2'b01;
    cpu_addr[0] = 7'd37;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b01) $display("FAIL single_gnt got %b want 01", cpu_gnt);
    else pass_cnt++;
    check_cnt++;
    if (bank_req !== 3'b010 || bank_addr[1] !== 5'd5 || bank_we !== 3'b000)
      $display("FAIL single_bank got req=%b addr=%0d we=%b want req=010 addr=5 we=000",
               bank_req, bank_addr[1], bank_we);
    else pass_cnt++;
    tick();
    idle();
    check_cnt++;
    if (cpu_rvalid !== 2'b01 || cpu_rdata[0] !== 32'hA000_0105 || cpu_err !== 2'b00)
      $display("FAIL single_rsp got rvalid=%b rdata=%h err=%b want 01 a0000105 00",
               cpu_rvalid, cpu_rdata[0], cpu_err);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (cpu_rvalid !== 2'b00) $display("FAIL single_quiet got %b want 00", cpu_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    cpu_req     = 2'b11;
    cpu_addr[0] = 7'd2;
    cpu_addr[1] = 7'd3;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 32'hA000_0002 : 32'hA000_0003;
      #1;
      check_cnt++;
      if (cpu_gnt !== exp_g) $display("FAIL rr_gnt%0d got %b want %b", i, cpu_gnt, exp_g);
      else pass_cnt++;
      tick();
      if (i == 3) idle();
      check_cnt++;
      if (cpu_rvalid !== exp_g || cpu_rdata[i % 2] !== exp_d)
        $display("FAIL rr_rsp%0d got rvalid=%b rdata=%h want %b %h",
                 i, cpu_rvalid, cpu_rdata[i % 2], exp_g, exp_d);
      else pass_cnt++;
    end
  endtask

  task automatic test_parallel();
    cpu_req     = 2'b11;
    cpu_addr[0] = 7'd10;
    cpu_addr[1] = 7'd70;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b11 || bank_req !== 3'b101 || bank_addr[0] !== 5'd10 ||
        bank_addr[2] !== 5'd6)
      $display("FAIL par_gnt got gnt=%b req=%b a0=%0d a2=%0d want 11 101 10 6",
               cpu_gnt, bank_req, bank_addr[0], bank_addr[2]);
    else pass_cnt++;
    tick();
    idle();
    check_cnt++;
    if (cpu_rvalid !== 2'b11 || cpu_rdata[0] !== 32'hA000_000A ||
        cpu_rdata[1] !== 32'hA000_0206 || cpu_err !== 2'b00)
      $display("FAIL par_rsp got rvalid=%b d0=%h d1=%h err=%b want 11 a000000a a0000206 00",
               cpu_rvalid, cpu_rdata[0], cpu_rdata[1], cpu_err);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_error();
    cpu_req     = 2'b10;
    cpu_addr[1] = 7'd100;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b10 || bank_req !== 3'b000)
      $display("FAIL err_gnt got gnt=%b req=%b want 10 000", cpu_gnt, bank_req);
    else pass_cnt++;
    tick();
    idle();
    check_cnt++;
    if (cpu_rvalid !== 2'b10 || cpu_err !== 2'b10 || cpu_rdata[1] !== 32'h0)
      $display("FAIL err_rsp got rvalid=%b err=%b rdata=%h want 10 10 0",
               cpu_rvalid, cpu_err, cpu_rdata[1]);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (cpu_err !== 2'b00) $display("FAIL err_clear got %b want 00", cpu_err);
    else pass_cnt++;
  endtask

  task automatic test_write();
    cpu_req      = 2'b01;
    cpu_we       = 2'b01;
    cpu_addr[0]  = 7'd64;
    cpu_wdata[0] = 32'hDEAD_BEEF;
    #1;
    check_cnt++;
    if (bank_req !== 3'b100 || bank_we !== 3'b100 || bank_addr[2] !== 5'd0 ||
        bank_wdata[2] !== 32'hDEAD_BEEF)
      $display("FAIL wr_bank got req=%b we=%b addr=%0d wdata=%h want 100 100 0 deadbeef",
               bank_req, bank_we, bank_addr[2], bank_wdata[2]);
    else pass_cnt++;
    tick();
    cpu_we = 2'b00;
    check_cnt++;
    if (cpu_rvalid !== 2'b01 || cpu_rdata[0] !== 32'h0 || cpu_err !== 2'b00)
      $display("FAIL wr_ack got rvalid=%b rdata=%h err=%b want 01 0 00",
               cpu_rvalid, cpu_rdata[0], cpu_err);
    else pass_cnt++;
    // Read the word back through the crossbar.
    tick();
    idle();
    check_cnt++;
    if (cpu_rvalid !== 2'b01 || cpu_rdata[0] !== 32'hDEAD_BEEF)
      $display("FAIL wr_readback got rvalid=%b rdata=%h want 01 deadbeef",
               cpu_rvalid, cpu_rdata[0]);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_req     = 2'b01;
    cpu_addr[0] = 7'd33;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b01) $display("FAIL b2b_gnt0 got %b want 01", cpu_gnt);
    else pass_cnt++;
    tick();
    cpu_addr[0] = 7'd34;
    check_cnt++;
    if (cpu_rvalid !== 2'b01 || cpu_rdata[0] !== 32'hA000_0101)
      $display("FAIL b2b_rsp0 got rvalid=%b rdata=%h want 01 a0000101", cpu_rvalid, cpu_rdata[0]);
    else pass_cnt++;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b01 || bank_addr[1] !== 5'd2)
      $display("FAIL b2b_gnt1 got gnt=%b addr=%0d want 01 2", cpu_gnt, bank_addr[1]);
    else pass_cnt++;
    tick();
    idle();
    check_cnt++;
    if (cpu_rvalid !== 2'b01 || cpu_rdata[0] !== 32'hA000_0102)
      $display("FAIL b2b_rsp1 got rvalid=%b rdata=%h want 01 a0000102", cpu_rvalid, cpu_rdata[0]);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_inflight();
    // CPU0 wins bank 0 here, so without a pointer reset CPU1 would win next contention.
    cpu_req     = 2'b01;
    cpu_addr[0] = 7'd1;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b01) $display("FAIL rst_pre_gnt got %b want 01", cpu_gnt);
    else pass_cnt++;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (cpu_rvalid !== 2'b00 || cpu_rdata[0] !== 32'h0)
      $display("FAIL rst_discard got rvalid=%b rdata=%h want 00 0", cpu_rvalid, cpu_rdata[0]);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    check_cnt++;
    if (cpu_rvalid !== 2'b00) $display("FAIL rst_no_replay got %b want 00", cpu_rvalid);
    else pass_cnt++;
    cpu_req     = 2'b11;
    cpu_addr[0] = 7'd1;
    cpu_addr[1] = 7'd2;
    #1;
    check_cnt++;
    if (cpu_gnt !== 2'b01) $display("FAIL rst_ptr_gnt got %b want 01", cpu_gnt);
    else pass_cnt++;
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_parallel();
    test_error();
    test_write();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout got still running want finished");
    $fatal(1, "timeout");
  end

endmodule
